pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector.sv | 152 +++++++++++++++
 tb/tb_pattern_detector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial masked pattern matcher with saturating hit counter
module pattern_detector #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rnot,
  input  logic             clr,
  input  logic             prgm_en,
  input  logic             prgm,
  input  logic             mask_bit,
  input  logic             sig_valid,
  input  logic             sig,
  input  logic             one_shot,
  output logic             match,
  output logic             armed,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_HIT   = 2'd3
  } state_t;

  // Load and fill counters must be able to hold the value WIDTH itself.
  localparam int LCW = $clog2(WIDTH + 1);
  localparam logic [LCW-1:0]   W_FULL  = LCW'(WIDTH);
  localparam logic [LCW-1:0]   W_LAST  = LCW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pattern;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_signal;
  logic [LCW-1:0]     r_load_cnt;
  logic [LCW-1:0]     r_fill;
  logic               r_match;
  logic               r_os;
  logic [CNT_W-1:0]   r_count;

  logic [WIDTH-1:0]   w_sig_next;
  logic [WIDTH-1:0]   w_pat_next;
  logic [WIDTH-1:0]   w_mask_next;
  logic [LCW-1:0]     w_fill_next;
  logic               w_qual;

  // Post-shift views of the shift registers; the match decision uses the window as it will be after this edge.
  always_comb begin
    w_sig_next  = {r_signal[WIDTH-2:0], sig};
    w_pat_next  = {r_pattern[WIDTH-2:0], prgm};
    w_mask_next = {r_mask[WIDTH-2:0], mask_bit};
    w_fill_next = (r_fill == W_FULL) ? W_FULL : r_fill + 1'b1;
    w_qual      = (w_fill_next == W_FULL) && (((w_sig_next ^ r_pattern) & r_mask) == '0);
  end

  // FSM, shift registers, counters and registered match pulse.
  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      r_state    <= ST_IDLE;
      r_pattern  <= '0;
      r_mask     <= '0;
      r_signal   <= '0;
      r_load_cnt <= '0;
      r_fill     <= '0;
      r_match    <= 1'b0;
      r_os       <= 1'b0;
      r_count    <= '0;
    end else if (clr) begin
      r_state    <= ST_IDLE;
      r_pattern  <= '0;
      r_mask     <= '0;
      r_signal   <= '0;
      r_load_cnt <= '0;
      r_fill     <= '0;
      r_match    <= 1'b0;
      r_os       <= 1'b0;
      r_count    <= '0;
    end else begin
      // match is a single-cycle pulse; the count follows it one edge later.
      r_match <= 1'b0;
      if (r_match && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (prgm_en) begin
            r_pattern  <= w_pat_next;
            r_mask     <= w_mask_next;
            r_load_cnt <= LCW'(1);
            r_state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (prgm_en) begin
            r_pattern  <= w_pat_next;
            r_mask     <= w_mask_next;
            r_load_cnt <= r_load_cnt + 1'b1;
            if (r_load_cnt == W_LAST) begin
              r_fill   <= '0;
              r_signal <= '0;
              r_state  <= ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (prgm_en) begin
            // Reprogramming wins over any pending signal shift.
            r_pattern  <= w_pat_next;
            r_mask     <= w_mask_next;
            r_load_cnt <= LCW'(1);
            r_fill     <= '0;
            r_state    <= ST_LOAD;
          end else if (r_match && r_os) begin
            // One-shot hit from the previous edge: stop here, no more shifting.
            r_state <= ST_HIT;
          end else if (sig_valid) begin
            r_signal <= w_sig_next;
            r_fill   <= w_fill_next;
            if (w_qual) begin
              r_match <= 1'b1;
              r_os    <= one_shot;
            end
          end
        end

        ST_HIT: begin
          if (prgm_en) begin
            r_pattern  <= w_pat_next;
            r_mask     <= w_mask_next;
            r_load_cnt <= LCW'(1);
            r_fill     <= '0;
            r_state    <= ST_LOAD;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign match = r_match;
  assign armed = (r_state == ST_ARMED);
  assign state = r_state;
  assign count = r_count;

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - scoreboard bench for pattern_detector at WIDTH=8
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       rnot = 1'b0;
  logic       clr = 1'b0;
  logic       prgm_en = 1'b0;
  logic       prgm = 1'b0;
  logic       mask_bit = 1'b0;
  logic       sig_valid = 1'b0;
  logic       sig = 1'b0;
  logic       one_shot = 1'b0;

  logic        match, armed;
  logic [1:0]  state;
  logic [15:0] count;
  logic        match2, armed2;
  logic [1:0]  state2;
  logic [1:0]  count2;

  typedef struct {
    int sh;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   done_shift = 0;
  logic inc_pend = 1'b0;
  int   inc_exp = 0;

  pattern_detector #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rnot(rnot), .clr(clr), .prgm_en(prgm_en), .prgm(prgm),
    .mask_bit(mask_bit), .sig_valid(sig_valid), .sig(sig), .one_shot(one_shot),
    .match(match), .armed(armed), .state(state), .count(count)
  );

  pattern_detector #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rnot(rnot), .clr(clr), .prgm_en(prgm_en), .prgm(prgm),
    .mask_bit(mask_bit), .sig_valid(sig_valid), .sig(sig), .one_shot(one_shot),
    .match(match2), .armed(armed2), .state(state2), .count(count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bits(input logic [7:0] pat, input logic [7:0] msk, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      prgm_en  = 1'b1;
      prgm     = pat[7-first-i];
      mask_bit = msk[7-first-i];
      tick();
    end
    prgm_en = 1'b0;
  endtask

  task automatic stream(input logic [15:0] data, input int n, input logic [15:0] hits);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sig_valid = 1'b1;
      sig       = data[n-1-i];
      if (hits[i]) begin
        e.sh  = i + 1;
        e.cnt = exp_cnt;
        q.push_back(e);
        if (exp_cnt < 65535) exp_cnt++;
      end
      tick();
      done_shift = i + 1;
    end
    sig_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_cnt = 0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
  endtask

  // Monitor: every match pulse must correspond to the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (inc_pend) begin
        inc_pend = 1'b0;
        chk("count_after_pulse", 32'(count), 32'(inc_exp));
      end
      if (match === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=1 required=0 after_shift=%0d", done_shift);
        end else begin
          e = q.pop_front();
          chk("pulse_shift", 32'(done_shift), 32'(e.sh));
          chk("count_at_pulse", 32'(count), 32'(e.cnt));
          inc_pend = 1'b1;
          inc_exp  = (e.cnt < 65535) ? e.cnt + 1 : e.cnt;
        end
      end
    end
  end

  initial begin
    // Reset held across several edges.
    tick(); tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rnot = 1'b1;
    tick();
    chk("release_state", 32'(state), 32'd0);
    chk("release_match", 32'(match), 32'd0);

    // Exact pattern A5, full mask.
    one_shot = 1'b0;
    load_bits(8'hA5, 8'hFF, 0, 8);
    chk("a5_state", 32'(state), 32'd2);
    chk("a5_armed", 32'(armed), 32'd1);
    stream(16'h00A5, 8, 16'h0080);
    drain("a5_drain");
    chk("a5_count", 32'(count), 32'd1);

    // Overlapping windows in continuous mode.
    do_clr();
    load_bits(8'hAA, 8'hFF, 0, 8);
    stream(16'h0AAA, 12, 16'h0A80);
    drain("aa_drain");
    chk("aa_count", 32'(count), 32'd3);

    // Partial mask: A7 matches A0/F0, B7 does not.
    do_clr();
    load_bits(8'hA0, 8'hF0, 0, 8);
    stream(16'hA7B7, 16, 16'h0080);
    drain("mask_drain");
    chk("mask_count", 32'(count), 32'd1);

    // One-shot: stop in HIT, ignore further signal, reprogram restarts.
    do_clr();
    one_shot = 1'b1;
    load_bits(8'hA5, 8'hFF, 0, 8);
    stream(16'h00A5, 8, 16'h0080);
    drain("os_drain");
    chk("os_state", 32'(state), 32'd3);
    chk("os_armed", 32'(armed), 32'd0);
    stream(16'h00A5, 8, 16'h0000);
    drain("os_hit_drain");
    chk("os_count", 32'(count), 32'd1);
    load_bits(8'hFF, 8'hFF, 0, 1);
    chk("os_reload_state", 32'(state), 32'd1);
    chk("os_reload_count", 32'(count), 32'd1);

    // Asynchronous reset mid-load, away from any clock edge.
    load_bits(8'hFF, 8'hFF, 1, 3);
    chk("midload_state", 32'(state), 32'd1);
    #2;
    rnot = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_match", 32'(match), 32'd0);
    tick();
    rnot = 1'b1;
    exp_cnt = 0;
    one_shot = 1'b0;
    tick();
    load_bits(8'hA5, 8'hFF, 0, 7);
    chk("reload7_state", 32'(state), 32'd1);
    load_bits(8'hA5, 8'hFF, 7, 1);
    chk("reload8_state", 32'(state), 32'd2);
    stream(16'h00A5, 8, 16'h0080);
    drain("reload_drain");
    chk("reload_count", 32'(count), 32'd1);

    // All-zero mask: every full-window shift matches; narrow counter saturates.
    do_clr();
    load_bits(8'h5A, 8'h00, 0, 8);
    stream(16'h0ABC, 12, 16'h0F80);
    drain("zmask_drain");
    chk("zmask_count", 32'(count), 32'd5);
    chk("sat_count", 32'(count2), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
